// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmit-arbiter state encoding
package uart_pkg;
    localparam int          UART_DATA_W          = 8;
    localparam int          CLK_HZ               = 50_000_000;
    localparam int          BAUD_DEFAULT         = 115_200;
    localparam logic [31:0] DEFAULT_HOLD_TIMEOUT = 32'd4340;
    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_HI, WAIT_LO} arb_state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first request after last
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;
    // scan farthest to nearest so the requester right after last wins
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(last) + k) % N);
            if (req[j]) idx = j;
        end
        any = |req;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular round-robin sharing of one byte UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] HOLD_TIMEOUT = DEFAULT_HOLD_TIMEOUT,
    localparam int         GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [8*NUM_REQ-1:0]     req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     utx_start,
    output logic [UART_DATA_W-1:0]   utx_data,
    input  logic                     utx_busy,
    output logic [GW-1:0]            grant_id,
    output logic                     grant_active,
    output logic                     frame_abort
);
    arb_state_t    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick_id;
    logic          pick_any;
    logic          last_q;
    logic [31:0]   timer;

    uart_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .idx  (pick_id),
        .any  (pick_any)
    );

    // only the owner sees ready, and only while waiting for its next byte
    always_comb req_ready = (state == GRANT) ? NUM_REQ'(1) << grant_id : '0;

    // arbitration and transmit handshake FSM
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state        <= IDLE;
            utx_start    <= 1'b0;
            utx_data     <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            frame_abort  <= 1'b0;
            last_grant   <= GW'(NUM_REQ - 1);
            last_q       <= 1'b0;
            timer        <= '0;
        end else begin
            utx_start   <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    grant_id     <= pick_id;
                    grant_active <= 1'b1;
                    timer        <= '0;
                    state        <= GRANT;
                end
                GRANT: if (req_valid[grant_id]) begin
                    utx_data  <= req_data[{grant_id, 3'b000} +: UART_DATA_W];
                    last_q    <= req_last[grant_id];
                    timer     <= '0;
                    utx_start <= 1'b1;
                    state     <= START;
                end else if (timer == HOLD_TIMEOUT - 32'd1) begin
                    frame_abort  <= 1'b1;
                    last_grant   <= grant_id;
                    grant_active <= 1'b0;
                    timer        <= '0;
                    state        <= IDLE;
                end else begin
                    timer <= timer + 32'd1;
                end
                START: state <= WAIT_HI;
                WAIT_HI: if (utx_busy) state <= WAIT_LO;
                WAIT_LO: if (!utx_busy) begin
                    timer <= '0;
                    if (last_q) begin
                        last_grant   <= grant_id;
                        grant_active <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        state <= GRANT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with frame-level round-robin reference model
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int HT = 16;
    typedef struct {logic [7:0] d; logic l; int gap;} ent_t;
    typedef struct {logic [7:0] d; int id;} exp_t;

    logic            tx_clk = 1'b0;
    logic            tx_rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            utx_start;
    logic [7:0]      utx_data;
    logic            utx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic            frame_abort;

    ent_t rq[NR][$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   aborts = 0;
    int   r3cnt = 0;
    int   busy_len = 4;
    int   mlast = NR - 1;
    logic [7:0] held = '0;

    always #5 tx_clk = ~tx_clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .HOLD_TIMEOUT(32'(HT))) dut (
        .tx_clk       (tx_clk),
        .tx_rst       (tx_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .utx_start    (utx_start),
        .utx_data     (utx_data),
        .utx_busy     (utx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .frame_abort  (frame_abort)
    );

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(int i, logic [7:0] d, logic l, int gap = 0);
        ent_t e;
        e.d = d;
        e.l = l;
        e.gap = gap;
        rq[i].push_back(e);
    endtask

    // frame-level round robin over requesters that have queued frames
    task automatic predict();
        ent_t cq[NR][$];
        int   ptr;
        bit   found;
        ptr = mlast;
        for (int i = 0; i < NR; i++) cq[i] = rq[i];
        do begin
            found = 0;
            for (int k = 1; k <= NR && !found; k++) begin
                int j;
                bit done;
                j = (ptr + k) % NR;
                if (cq[j].size() > 0) begin
                    found = 1;
                    ptr = j;
                    done = 0;
                    while (!done && cq[j].size() > 0) begin
                        ent_t e;
                        exp_t x;
                        e = cq[j].pop_front();
                        x.d = e.d;
                        x.id = j;
                        sb.push_back(x);
                        done = e.l;
                    end
                end
            end
        end while (found);
        mlast = ptr;
    endtask

    function automatic bit pending();
        pending = sb.size() > 0 || grant_active || utx_busy;
        for (int i = 0; i < NR; i++) if (rq[i].size() > 0) pending = 1;
    endfunction

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(negedge tx_clk);
            n++;
        end
        chk({name, "_drained"}, int'(n < budget), 1);
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) rq[i].delete();
        sb.delete();
    endtask

    task automatic chk_reset_outputs(string name);
        chk({name, "_ready"}, int'(req_ready), 0);
        chk({name, "_start"}, int'(utx_start), 0);
        chk({name, "_data"}, int'(utx_data), 0);
        chk({name, "_gid"}, int'(grant_id), 0);
        chk({name, "_gact"}, int'(grant_active), 0);
        chk({name, "_abort"}, int'(frame_abort), 0);
    endtask

    // transmitter model: busy rises the cycle after start, holds busy_len cycles
    initial begin : xmit
        int   rem;
        logic s;
        rem = 0;
        forever begin
            @(negedge tx_clk);
            s = utx_start;
            @(posedge tx_clk);
            #1;
            if (tx_rst) begin
                utx_busy = 1'b0;
                rem = 0;
            end else if (s && !utx_busy) begin
                utx_busy = 1'b1;
                rem = busy_len;
            end else if (utx_busy) begin
                rem--;
                if (rem == 0) utx_busy = 1'b0;
            end
        end
    end

    // requester models: present queue heads, pop on handshake, honour gaps
    initial begin : drv
        logic [NR-1:0] hs;
        forever begin
            @(negedge tx_clk);
            hs = req_valid & req_ready;
            @(posedge tx_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = 1'b0;
                if (rq[i].size() > 0) begin
                    ent_t e;
                    e = rq[i][0];
                    if (e.gap > 0) begin
                        e.gap--;
                        rq[i][0] = e;
                    end else begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = e.d;
                        req_last[i] = e.l;
                    end
                end
            end
        end
    end

    // monitor: scoreboard pops on every start, plus per-cycle protocol checks
    initial begin : mon
        forever begin
            @(negedge tx_clk);
            if (!tx_rst) begin
                if (frame_abort) aborts++;
                if (req_ready[3]) r3cnt++;
                checks++;
                if ((req_ready & ~(NR'(1) << grant_id)) != 0 || (req_ready != 0 && !grant_active)) begin
                    failures++;
                    $display("FAIL ready_owner req_ready=%b grant_id=%0d grant_active=%b", req_ready, grant_id, grant_active);
                end
                if (utx_busy) begin
                    checks++;
                    if (utx_data !== held) begin
                        failures++;
                        $display("FAIL data_stable actual=%h required=%h", utx_data, held);
                    end
                end
                if (utx_start) begin
                    checks++;
                    if (utx_busy) begin
                        failures++;
                        $display("FAIL start_in_busy start=1 while busy=1");
                    end
                    held = utx_data;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_start data=%h grant_id=%0d", utx_data, grant_id);
                    end else begin
                        exp_t x;
                        x = sb.pop_front();
                        checks += 2;
                        if (utx_data !== x.d) begin
                            failures++;
                            $display("FAIL tx_data actual=%h required=%h", utx_data, x.d);
                        end
                        if (int'(grant_id) != x.id) begin
                            failures++;
                            $display("FAIL tx_owner actual=%0d required=%0d", grant_id, x.id);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        @(negedge tx_clk);
        chk_reset_outputs("rst0");
        tx_rst = 1'b0;

        // single-byte frame from requester 1: latency and release timing
        @(negedge tx_clk);
        add(1, 8'h54, 1'b1);
        predict();
        @(posedge tx_clk);
        @(negedge tx_clk);
        chk("t1_ready_early", int'(req_ready[1]), 0);
        @(negedge tx_clk);
        chk("t1_ready", int'(req_ready[1]), 1);
        @(negedge tx_clk);
        chk("t1_start", int'(utx_start), 1);
        @(negedge tx_clk);
        chk("t1_start_pulse", int'(utx_start), 0);
        n = 0;
        while (!utx_busy && n < 50) begin @(negedge tx_clk); n++; end
        while (utx_busy && n < 50) begin @(negedge tx_clk); n++; end
        chk("t1_busy_seen", int'(n < 50), 1);
        chk("t1_gact_hold", int'(grant_active), 1);
        @(negedge tx_clk);
        chk("t1_gact_fall", int'(grant_active), 0);
        wait_idle("t1", 200);

        // all four requesters continuously valid: rotation from requester 0
        tx_rst = 1'b1;
        @(negedge tx_clk);
        flush();
        mlast = NR - 1;
        tx_rst = 1'b0;
        @(negedge tx_clk);
        add(0, 8'h30, 1'b1); add(1, 8'h31, 1'b1); add(2, 8'h32, 1'b1); add(3, 8'h33, 1'b1); add(0, 8'h30, 1'b1);
        predict();
        wait_idle("t2", 500);

        // frame lock: requester 2's three-byte frame finishes before requester 0
        add(2, 8'h41, 1'b0); add(2, 8'h42, 1'b0); add(2, 8'h43, 1'b1); add(0, 8'h10, 1'b1);
        predict();
        wait_idle("t3", 500);

        // hold timeout: requester 3 stalls mid-frame, requester 0 takes over
        r3cnt = 0;
        n = aborts;
        add(3, 8'h55, 1'b0);
        add(0, 8'h60, 1'b1);
        sb.push_back('{8'h55, 3});
        sb.push_back('{8'h60, 0});
        mlast = 0;
        wait_idle("t4", 500);
        chk("t4_abort_count", aborts - n, 1);
        chk("t4_grant_cycles", r3cnt, HT + 1);

        // slow transmitter with back-to-back bytes from one requester
        busy_len = 4340;
        add(1, 8'hA0, 1'b0); add(1, 8'hA1, 1'b0); add(1, 8'hA2, 1'b1);
        predict();
        wait_idle("t5", 20000);

        // randomized frames with short mid-frame stalls
        for (int r = 0; r < 6; r++) begin
            busy_len = $urandom_range(3, 12);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int nf;
                    nf = $urandom_range(1, 2);
                    for (int f = 0; f < nf; f++) begin
                        int nb;
                        nb = $urandom_range(1, 3);
                        for (int b = 0; b < nb; b++)
                            add(i, 8'($urandom), b == nb - 1, b == 0 ? 0 : $urandom_range(0, 8));
                    end
                end
            end
            predict();
            wait_idle("rand", 3000);
        end

        // asynchronous reset while waiting for busy to fall
        busy_len = 20;
        add(1, 8'h77, 1'b0); add(1, 8'h78, 1'b1);
        predict();
        n = 0;
        while (!utx_busy && n < 50) begin @(negedge tx_clk); n++; end
        chk("t6_busy_seen", int'(n < 50), 1);
        @(posedge tx_clk);
        @(negedge tx_clk);
        tx_rst = 1'b1;
        #1;
        chk_reset_outputs("t6_rst");
        flush();
        repeat (2) @(negedge tx_clk);
        tx_rst = 1'b0;
        mlast = NR - 1;
        @(negedge tx_clk);
        add(2, 8'h22, 1'b1);
        add(0, 8'h20, 1'b1);
        predict();
        wait_idle("t6", 500);

        chk("abort_total", aborts, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one byte-level UART transmitter (start/busy interface, 8N1 framing at the configured baud) between NUM_REQ requesters. Round-robin arbitration at frame granularity: a granted requester holds the transmitter until its last byte completes, or until it stalls past a timeout. Sits between the on-chip message sources (status, debug, test-pattern generators) and the single UART TX pin driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_TIMEOUT, 32'd4340, cycles a granted requester may leave req_valid low mid-frame before the grant is revoked (about one 115200 8N1 character time at 50 MHz)
GW, $clog2(NUM_REQ) (min 1), width of grant_id (derived; not to be overridden)

Ports:
tx_clk  in  1  system clock (50 MHz)
tx_rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  requester i byte on bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the last of its frame (sampled with valid)
req_ready  out  NUM_REQ  byte accepted when valid&ready
utx_start  out  1  one-cycle pulse to the transmitter
utx_data  out  8  byte to transmit, stable from start until busy falls
utx_busy  in  1  transmitter busy; rises the cycle after start, falls after the stop bit
grant_id  out  GW  current owner
grant_active  out  1  a requester owns the transmitter
frame_abort  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- One clock, tx_clk; tx_rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready 0, utx_start 0, utx_data 8'h00, grant_id 0, grant_active 0, frame_abort 0, last_grant NUM_REQ-1 (requester 0 wins first), hold timer 0.
- States: IDLE, GRANT, START, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid, select the first set bit searching from last_grant+1 upward, wrapping at NUM_REQ.
  - Register grant_id, set grant_active=1, go to GRANT.
  - With no request, remain in IDLE.
- GRANT:
  - req_ready[grant_id]=1; all other ready bits are 0. req_ready is combinational from state and grant_id.
  - If req_valid[grant_id]: latch the byte into utx_data, latch req_last, clear the timer, go to START.
  - Otherwise increment the timer. When the timer reaches HOLD_TIMEOUT-1: pulse frame_abort, set last_grant=grant_id, clear grant_active, go to IDLE.
- START: utx_start=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: wait for utx_busy=1, then go to WAIT_LO. No timeout.
- WAIT_LO: wait for utx_busy=0.
  - If the latched last=1: set last_grant=grant_id, clear grant_active, go to IDLE.
  - Otherwise go to GRANT with the timer cleared.
- Arbitration latency: a request in IDLE sees ready 1 cycle later and utx_start 2 cycles later.
- Frame lock: other requesters' valid/data are ignored while grant_active=1, regardless of their last flags.
- Simultaneous events: a new request arriving in the release cycle is arbitrated in the next IDLE cycle. The releasing requester has the lowest priority on that pass.
- A single-byte frame is a byte with req_last=1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). Any character already in flight in the transmitter is not tracked. After reset, arbitration restarts from requester 0.
- Bit arithmetic: the grant pointer increments modulo NUM_REQ. The hold timer is 32 bits and saturates at HOLD_TIMEOUT-1.

Decomposition:
- Shared package uart_pkg: state encoding constants, UART_DATA_W=8, CLK_HZ=50_000_000, BAUD_DEFAULT=115_200, DEFAULT_HOLD_TIMEOUT.
- One sub-module: uart_rr_pick, a combinational round-robin picker (inputs: request vector, last_grant; outputs: index, any). It is reused by future RX-side and command arbiters.

Test Plan:
- Reset; req1 sends 0x54 with last=1 -> ready[1] 1 cycle after valid, utx_start single pulse, utx_data=0x54; grant_active falls the cycle after busy falls.
- Reqs 0..3 all valid with single-byte frames 0x30..0x33 held continuously -> transmit order 0x30,0x31,0x32,0x33,0x30.
- Req2 sends frame 0x41,0x42,0x43 (last on 0x43) while req0 is valid throughout -> req0 not granted until after the 0x43 busy falls; ready[0] stays 0 meanwhile.
- HOLD_TIMEOUT=16: req3 sends 0x55 with last=0, then drops valid -> frame_abort pulses on the 16th GRANT cycle; a pending req0 is granted next; no extra utx_start.
- Slow transmitter (busy held 4340 cycles per byte) with back-to-back bytes from one requester -> exactly one start per busy period; utx_data stable throughout busy.
- Assert tx_rst while in WAIT_LO -> all outputs reach reset values in the same cycle; after release, requester 0 wins over a simultaneous req2.
